// File: rtl/phase_gen.sv
// Multi-cycle instruction phase sequencer: one-hot P0..P4 phase register,
// class decode latched at decode exit, handshake-driven strobes and retire counter.
module phase_gen #(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [5:0]          op,
  input  logic [5:0]          irfunc,
  output logic [4:0]          p,
  output logic                mem_req,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_write,
  output logic                reg_write,
  output logic                instr_done,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [4:0] {
    P0 = 5'b00001,
    P1 = 5'b00010,
    P2 = 5'b00100,
    P3 = 5'b01000,
    P4 = 5'b10000
  } phase_t;

  // Cleared class value is ILLEGAL so a stale class can never retire anything.
  typedef enum logic [1:0] {
    CL_ILL = 2'd0,
    CL_ADD = 2'd1,
    CL_LW  = 2'd2,
    CL_SW  = 2'd3
  } cls_t;

  phase_t              phase_q, phase_d;
  cls_t                cls_q, dec_cls;
  logic [RETIRE_W-1:0] retired_q;
  logic                retire_inc;

  // Instruction class decode, meaningful only while in P1.
  always_comb begin
    dec_cls = CL_ILL;
    if (op == OP_RTYPE && irfunc == FN_ADD) begin
      dec_cls = CL_ADD;
    end else if (op == OP_LW) begin
      dec_cls = CL_LW;
    end else if (op == OP_SW) begin
      dec_cls = CL_SW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= P0;
      cls_q     <= CL_ILL;
      retired_q <= '0;
    end else begin
      phase_q <= phase_d;
      if (phase_q == P1) begin
        cls_q <= dec_cls;
      end
      if (retire_inc) begin
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

  // Next phase and strobes; strobes forced low while reset is asserted.
  always_comb begin
    phase_d    = phase_q;
    mem_req    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    retire_inc = 1'b0;
    case (phase_q)
      P0: begin
        if (run) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            pc_write = 1'b1;
            ir_write = 1'b1;
            phase_d  = P1;
          end
        end
      end
      P1: begin
        if (dec_cls == CL_ILL) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          phase_d    = P0;
        end else begin
          phase_d = P2;
        end
      end
      P2: begin
        phase_d = (cls_q == CL_ADD) ? P4 : P3;
      end
      P3: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          if (cls_q == CL_SW) begin
            mem_write  = 1'b1;
            instr_done = 1'b1;
            retire_inc = 1'b1;
            phase_d    = P0;
          end else begin
            phase_d = P4;
          end
        end
      end
      P4: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        retire_inc = 1'b1;
        phase_d    = P0;
      end
      default: phase_d = P0;
    endcase
    if (rst) begin
      mem_req    = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      retire_inc = 1'b0;
    end
  end

  assign p       = phase_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_phase_gen.sv
// Bench for phase_gen: directed vector table, hand sequences for reset/wrap,
// and randomized traffic checked against a per-class phase-list model.
module tb_phase_gen;

  logic        clk = 1'b0;
  logic        rst, run, mem_ready;
  logic [5:0]  op, irfunc;
  logic [4:0]  p;
  logic        mem_req, pc_write, ir_write, mem_write, reg_write, instr_done, illegal;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  phase_gen #(.RETIRE_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_ready(mem_ready), .op(op), .irfunc(irfunc),
    .p(p), .mem_req(mem_req), .pc_write(pc_write), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .instr_done(instr_done),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // Class codes used by the model: 0 ADD, 1 LW, 2 SW, 3 ILLEGAL.
  int          m_idx = 0;
  int          m_cls = 3;
  logic [15:0] m_ret = '0;
  logic [27:0] act;

  function automatic int dec(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000 && f == 6'b100000) return 0;
    if (o == 6'b100011) return 1;
    if (o == 6'b101011) return 2;
    return 3;
  endfunction

  // Phase visited at position i of each class's instruction.
  function automatic int ph_at(input int c, input int i);
    int a[5];
    case (c)
      0:       a = '{0, 1, 2, 4, 0};
      1:       a = '{0, 1, 2, 3, 4};
      2:       a = '{0, 1, 2, 3, 0};
      default: a = '{0, 1, 0, 0, 0};
    endcase
    return a[i];
  endfunction

  function automatic int seq_len(input int c);
    case (c)
      0:       return 4;
      1:       return 5;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string name, input logic [27:0] a, input logic [27:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc %0d actual p=%b str=%b ret=%h required p=%b str=%b ret=%h",
               name, cyc, a[27:23], a[22:16], a[15:0], e[27:23], e[22:16], e[15:0]);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance the model at posedge.
  task automatic drive(input logic r, input logic ru, input logic mr,
                       input logic [5:0] o, input logic [5:0] f);
    int   cls_now, ph;
    logic req, comp, last, done;
    logic [6:0] e_str;
    @(negedge clk);
    rst = r; run = ru; mem_ready = mr; op = o; irfunc = f;
    #1;
    cls_now = (m_idx == 1) ? dec(o, f) : m_cls;
    ph      = (m_idx < 2) ? m_idx : ph_at(m_cls, m_idx);
    req     = (ph == 0 && ru) || ph == 3;
    comp    = (ph == 0 || ph == 3) ? (req && mr) : 1'b1;
    last    = (m_idx == seq_len(cls_now) - 1);
    done    = comp && last && ph != 0;
    e_str   = {req, ph == 0 && comp, ph == 0 && comp, ph == 3 && comp && cls_now == 2,
               ph == 4, done, ph == 1 && cls_now == 3};
    if (r) e_str = '0;
    act = {p, mem_req, pc_write, ir_write, mem_write, reg_write, instr_done, illegal, retired};
    check("model", act, {5'(1 << ph), e_str, m_ret});
    @(posedge clk);
    cyc++;
    if (r) begin
      m_idx = 0; m_cls = 3; m_ret = '0;
    end else if (done) begin
      m_idx = 0;
      if (cls_now != 3) m_ret++;
    end else if (comp) begin
      if (m_idx == 1) m_cls = cls_now;
      m_idx++;
    end
  endtask

  typedef struct {
    logic        r, ru, mr;
    logic [5:0]  o, f;
    logic [4:0]  ep;
    logic [6:0]  es;   // {mem_req,pc_write,ir_write,mem_write,reg_write,instr_done,illegal}
    logic [15:0] er;
  } vec_t;

  localparam logic [5:0] A = 6'h00, FA = 6'h20, L = 6'h23, S = 6'h2B, X = 6'h04;

  vec_t tbl[29];

  initial begin
    tbl[0]  = '{1, 1, 1, A, FA, 5'b00001, 7'b0000000, 16'd0};
    tbl[1]  = '{0, 1, 1, A, FA, 5'b00001, 7'b1110000, 16'd0};
    tbl[2]  = '{0, 0, 0, A, FA, 5'b00010, 7'b0000000, 16'd0};
    tbl[3]  = '{0, 0, 0, A, FA, 5'b00100, 7'b0000000, 16'd0};
    tbl[4]  = '{0, 0, 0, A, FA, 5'b10000, 7'b0000110, 16'd0};
    tbl[5]  = '{0, 0, 0, A, FA, 5'b00001, 7'b0000000, 16'd1};
    tbl[6]  = '{0, 1, 0, A, FA, 5'b00001, 7'b1000000, 16'd1};
    tbl[7]  = '{0, 1, 1, A, FA, 5'b00001, 7'b1110000, 16'd1};
    tbl[8]  = '{0, 0, 1, L, 0,  5'b00010, 7'b0000000, 16'd1};
    tbl[9]  = '{0, 0, 1, L, 0,  5'b00100, 7'b0000000, 16'd1};
    tbl[10] = '{0, 0, 0, A, FA, 5'b01000, 7'b1000000, 16'd1};
    tbl[11] = '{0, 0, 0, S, 0,  5'b01000, 7'b1000000, 16'd1};
    tbl[12] = '{0, 0, 1, S, 0,  5'b01000, 7'b1000000, 16'd1};
    tbl[13] = '{0, 0, 0, A, FA, 5'b10000, 7'b0000110, 16'd1};
    tbl[14] = '{0, 0, 0, A, FA, 5'b00001, 7'b0000000, 16'd2};
    tbl[15] = '{0, 1, 1, A, FA, 5'b00001, 7'b1110000, 16'd2};
    tbl[16] = '{0, 0, 1, S, 0,  5'b00010, 7'b0000000, 16'd2};
    tbl[17] = '{0, 0, 1, S, 0,  5'b00100, 7'b0000000, 16'd2};
    tbl[18] = '{0, 0, 1, S, 0,  5'b01000, 7'b1001010, 16'd2};
    tbl[19] = '{0, 0, 0, A, FA, 5'b00001, 7'b0000000, 16'd3};
    tbl[20] = '{0, 1, 1, A, FA, 5'b00001, 7'b1110000, 16'd3};
    tbl[21] = '{0, 0, 1, X, 0,  5'b00010, 7'b0000011, 16'd3};
    tbl[22] = '{0, 0, 1, A, FA, 5'b00001, 7'b0000000, 16'd3};
    tbl[23] = '{0, 1, 1, A, FA, 5'b00001, 7'b1110000, 16'd3};
    tbl[24] = '{0, 0, 0, L, 0,  5'b00010, 7'b0000000, 16'd3};
    tbl[25] = '{0, 0, 0, L, 0,  5'b00100, 7'b0000000, 16'd3};
    tbl[26] = '{0, 0, 0, L, 0,  5'b01000, 7'b1000000, 16'd3};
    tbl[27] = '{1, 0, 0, L, 0,  5'b01000, 7'b0000000, 16'd3};
    tbl[28] = '{0, 0, 0, A, FA, 5'b00001, 7'b0000000, 16'd0};

    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; op = '0; irfunc = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].r, tbl[i].ru, tbl[i].mr, tbl[i].o, tbl[i].f);
      check($sformatf("vec%0d", i), act, {tbl[i].ep, tbl[i].es, tbl[i].er});
    end

    // Idle in P0 with run low, stray mem_ready ignored.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'(i % 2), A, FA);
      check("idle", act, {5'b00001, 7'b0000000, 16'd0});
    end

    // Retire counter wrap: preset to all ones, then one ADD.
    @(negedge clk);
    dut.retired_q = 16'hFFFF;
    m_ret = 16'hFFFF;
    drive(1'b0, 1'b1, 1'b1, A, FA);
    drive(1'b0, 1'b0, 1'b1, A, FA);
    drive(1'b0, 1'b0, 1'b1, A, FA);
    drive(1'b0, 1'b0, 1'b1, A, FA);
    check("pre_wrap", act, {5'b10000, 7'b0000110, 16'hFFFF});
    drive(1'b0, 1'b0, 1'b0, A, FA);
    check("wrap", act, {5'b00001, 7'b0000000, 16'h0000});

    // Randomized traffic against the phase-list model.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] o, f;
      case ($urandom % 5)
        0:       begin o = A; f = FA; end
        1:       begin o = L; f = 6'($urandom); end
        2:       begin o = S; f = 6'($urandom); end
        3:       begin o = A; f = 6'($urandom); end
        default: begin o = 6'($urandom); f = 6'($urandom); end
      endcase
      drive(1'(($urandom % 64) == 0), 1'(($urandom % 4) != 0), 1'($urandom % 2), o, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
